// File: rtl/psum_accum.sv
// Partial-sum accumulator: pulls rows from an upstream FIFO, accumulates them
// across passes and emits the ReLU of each row on the final pass.
module psum_accum #(
  parameter int col       = 8,
  parameter int psum_bw   = 16,
  parameter int acc_depth = 16,
  parameter int rd_lat    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             n_pass,
  input  logic [4:0]             n_rows,
  input  logic                   fifo_valid,
  output logic                   fifo_rd,
  input  logic [col*psum_bw-1:0] fifo_data,
  output logic                   out_valid,
  output logic [3:0]             out_addr,
  output logic [col*psum_bw-1:0] out_data,
  output logic                   busy,
  output logic                   done
);

  localparam int W  = col * psum_bw;
  localparam int AW = (acc_depth > 1) ? $clog2(acc_depth) : 1;
  localparam logic [4:0] DEPTH = 5'(acc_depth);
  localparam logic [1:0] WLAST = 2'((rd_lat >= 2) ? rd_lat - 2 : 0);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, ACC, DONE} state_t;

  state_t       state_q;
  logic [4:0]   row_q, nrows_q;
  logic [3:0]   pass_q, npass_q;
  logic [1:0]   wcnt_q;
  logic         busy_q, done_q, out_valid_q;
  logic [3:0]   out_addr_q;
  logic [W-1:0] hold_q;
  logic [W-1:0] acc_q [acc_depth];

  logic [W-1:0]       sum_row, relu_row;
  logic [psum_bw-1:0] lane_f, lane_a, lane_s;
  logic               last_pass, last_row;

  assign last_pass = (pass_q == npass_q - 4'd1);
  assign last_row  = (row_q == nrows_q - 5'd1);

  always_comb begin
    sum_row  = '0;
    relu_row = '0;
    lane_f   = '0;
    lane_a   = '0;
    lane_s   = '0;
    for (int unsigned i = 0; i < col; i++) begin
      lane_f = fifo_data[i*psum_bw +: psum_bw];
      lane_a = acc_q[row_q[AW-1:0]][i*psum_bw +: psum_bw];
      lane_s = (pass_q == '0) ? lane_f : lane_a + lane_f;
      sum_row[i*psum_bw +: psum_bw]  = lane_s;
      relu_row[i*psum_bw +: psum_bw] = lane_s[psum_bw-1] ? '0 : lane_s;
    end
  end

  // The pop request is issued in the REQ cycle itself so that data returned
  // rd_lat cycles later lines up exactly with the ACC cycle.
  assign fifo_rd   = (state_q == REQ) && fifo_valid;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_valid_q ? relu_row : hold_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      pass_q      <= '0;
      npass_q     <= '0;
      nrows_q     <= '0;
      wcnt_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      hold_q      <= '0;
    end else begin
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= REQ;
          busy_q  <= 1'b1;
          row_q   <= '0;
          pass_q  <= '0;
          npass_q <= (n_pass == '0) ? 4'd1 : n_pass;
          nrows_q <= (n_rows == '0 || n_rows > DEPTH) ? DEPTH : n_rows;
        end
        REQ: if (fifo_valid) begin
          wcnt_q <= '0;
          if (rd_lat <= 1) begin
            state_q     <= ACC;
            out_valid_q <= last_pass;
            out_addr_q  <= row_q[3:0];
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: if (wcnt_q == WLAST) begin
          state_q     <= ACC;
          out_valid_q <= last_pass;
          out_addr_q  <= row_q[3:0];
        end else begin
          wcnt_q <= wcnt_q + 2'd1;
        end
        ACC: begin
          if (last_pass) hold_q <= relu_row;
          if (last_row) begin
            row_q  <= '0;
            pass_q <= pass_q + 4'd1;
            if (last_pass) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= REQ;
            end
          end else begin
            row_q   <= row_q + 5'd1;
            state_q <= REQ;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state_q == ACC) acc_q[row_q[AW-1:0]] <= sum_row;
  end

endmodule

// File: tb/tb_psum_accum.sv
// Randomized bench for psum_accum: an upstream FIFO model feeds rows and a
// scoreboard holds the per-row ReLU of the wrapped per-lane sums.
module tb_psum_accum;
  localparam int COL = 8, PBW = 16, DEPTH = 16, RD_LAT = 2, W = COL * PBW;

  logic         clk = 1'b0;
  logic         reset, start, fifo_valid, fifo_rd, out_valid, busy, done;
  logic [3:0]   n_pass, out_addr;
  logic [4:0]   n_rows;
  logic [W-1:0] fifo_data, out_data;

  psum_accum #(.col(COL), .psum_bw(PBW), .acc_depth(DEPTH), .rd_lat(RD_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .n_pass(n_pass), .n_rows(n_rows),
    .fifo_valid(fifo_valid), .fifo_rd(fifo_rd), .fifo_data(fifo_data),
    .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [W-1:0] data; } rd_t;
  typedef struct { logic [3:0] addr; logic [W-1:0] data; } out_t;

  rd_t          pend[$];
  out_t         exp_q[$];
  logic [W-1:0] stream[$];
  logic [W-1:0] got [DEPTH];
  out_t         last_exp;
  int vectors = 0, miscompares = 0, cyc = 0, reads = 0, exp_reads = 0;
  int outs_seen = 0, dones = 0, prev_rd = -1;
  bit steady = 1'b0, fv_rand = 1'b0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rnd_row();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [W-1:0] row2(input logic [15:0] l0, input logic [15:0] l1);
    logic [W-1:0] r;
    r = '0;
    r[15:0]  = l0;
    r[31:16] = l1;
    return r;
  endfunction

  // Upstream FIFO: data appears exactly RD_LAT cycles after the pop, garbage otherwise.
  initial begin
    fifo_data = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        fifo_data = pend[0].data;
        void'(pend.pop_front());
      end else begin
        fifo_data = rnd_row();
      end
      if (fv_rand) fifo_valid = 1'($urandom_range(0, 1));
    end
  end

  // Single compare process, sampling mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (fifo_rd) begin
          rd_t p;
          chk("rd_needs_valid", W'(fifo_valid), W'(1));
          chk("one_outstanding", W'(pend.size()), '0);
          chk("read_within_job", W'(stream.size() > 0), W'(1));
          if (steady && prev_rd >= 0) chk("rd_interval", W'(cyc - prev_rd), W'(RD_LAT + 1));
          prev_rd = cyc;
          reads++;
          if (stream.size() > 0) begin
            p.due  = cyc + RD_LAT;
            p.data = stream.pop_front();
            pend.push_back(p);
          end
        end
        if (out_valid) begin
          outs_seen++;
          got[out_addr] = out_data;
          if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", W'(out_valid), '0);
          end else begin
            out_t e;
            e = exp_q.pop_front();
            chk("out_addr", W'(out_addr), W'(e.addr));
            chk("out_data", out_data, e.data);
          end
        end
        if (done) begin
          dones++;
          chk("busy_at_done", W'(busy), W'(1));
          chk("reads_at_done", W'(reads), W'(exp_reads));
          chk("outs_left_at_done", W'(exp_q.size()), '0);
        end
      end
    end
  end

  task automatic run_job(input logic [3:0] np_in, input logic [4:0] nr_in,
                         input bit rnd_fv, input int hold_lo, input bit poke);
    int np, nr, t, d0;
    logic signed [15:0] s;
    out_t e;
    np = (np_in == 0) ? 1 : int'(np_in);
    nr = (nr_in == 0 || nr_in > 5'(DEPTH)) ? DEPTH : int'(nr_in);
    if (stream.size() == 0) for (int i = 0; i < np * nr; i++) stream.push_back(rnd_row());
    exp_q.delete();
    for (int r = 0; r < nr; r++) begin
      e.addr = 4'(r);
      e.data = '0;
      for (int l = 0; l < COL; l++) begin
        s = '0;
        for (int p = 0; p < np; p++) s = s + $signed(stream[p*nr + r][l*PBW +: PBW]);
        e.data[l*PBW +: PBW] = (s < 0) ? 16'd0 : s;
      end
      exp_q.push_back(e);
    end
    last_exp  = exp_q[exp_q.size() - 1];
    exp_reads = np * nr;
    reads     = 0;
    outs_seen = 0;
    prev_rd   = -1;
    steady    = !rnd_fv;
    d0        = dones;
    fifo_valid = (hold_lo > 0) ? 1'b0 : 1'b1;
    @(posedge clk); #1;
    n_pass = np_in; n_rows = nr_in; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; n_pass = 4'($urandom); n_rows = 5'($urandom);
    fv_rand = rnd_fv;
    for (int i = 0; i < hold_lo; i++) begin
      @(negedge clk); #1;
      chk("hold_no_rd", W'(fifo_rd), '0);
      chk("hold_busy", W'(busy), W'(1));
    end
    if (hold_lo > 0) begin
      @(posedge clk); #1;
      fifo_valid = 1'b1;
    end
    if (poke) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1; n_pass = 4'd7; n_rows = 5'd3;
      @(posedge clk); #1 start = 1'b0;
    end
    t = 0;
    while (dones == d0 && t < 5000) begin
      @(negedge clk); #1;
      t++;
    end
    fv_rand = 1'b0;
    if (dones == d0) begin
      chk("done_timeout", W'(dones), W'(d0 + 1));
      return;
    end
    @(negedge clk); #1;
    chk("idle_busy", W'(busy), '0);
    chk("done_one_cycle", W'(done), '0);
    chk("hold_out_addr", W'(out_addr), W'(last_exp.addr));
    chk("hold_out_data", out_data, last_exp.data);
    chk("stream_consumed", W'(stream.size()), '0);
  endtask

  initial begin
    int t;
    reset = 1'b1; start = 1'b0; fifo_valid = 1'b0; n_pass = '0; n_rows = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_fifo_rd", W'(fifo_rd), '0);
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_out_addr", W'(out_addr), '0);
    chk("rst_out_data", out_data, '0);

    // Two rows, one pass: negative lane clipped by ReLU.
    stream.push_back(row2(16'd5, -16'sd3));
    stream.push_back(row2(16'd7, 16'd0));
    run_job(4'd1, 5'd2, 1'b0, 0, 1'b0);
    chk("t1_outs", W'(outs_seen), W'(2));
    chk("t1_a0_l0", W'(got[0][15:0]), W'(5));
    chk("t1_a0_l1", W'(got[0][31:16]), '0);
    chk("t1_a1_l0", W'(got[1][15:0]), W'(7));

    // Three passes summing to -130 -> 0; only the last pass produces output.
    stream.push_back(row2(16'd100, 16'd1));
    stream.push_back(row2(-16'sd250, 16'd2));
    stream.push_back(row2(16'd20, 16'd3));
    run_job(4'd3, 5'd1, 1'b0, 0, 1'b0);
    chk("t2_outs", W'(outs_seen), W'(1));
    chk("t2_l0", W'(got[0][15:0]), '0);
    chk("t2_l1", W'(got[0][31:16]), W'(6));

    // Positive overflow wraps negative and is clipped.
    stream.push_back(row2(16'd32767, 16'd1000));
    stream.push_back(row2(16'd1, 16'd2000));
    run_job(4'd2, 5'd1, 1'b0, 0, 1'b0);
    chk("t3_wrap_l0", W'(got[0][15:0]), '0);
    chk("t3_l1", W'(got[0][31:16]), W'(3000));

    // Upstream empty for 10 cycles.
    run_job(4'd1, 5'd3, 1'b0, 10, 1'b0);

    // Row-count limits and pass-count zero.
    run_job(4'd1, 5'd0, 1'b0, 0, 1'b0);
    chk("t5_outs16", W'(outs_seen), W'(16));
    run_job(4'd0, 5'd20, 1'b0, 0, 1'b0);
    chk("t6_outs16", W'(outs_seen), W'(16));

    // start while busy has no effect.
    run_job(4'd3, 5'd4, 1'b0, 0, 1'b1);

    // Reset while waiting on the FIFO.
    for (int i = 0; i < 8; i++) stream.push_back(rnd_row());
    exp_q.delete();
    exp_reads = 8; reads = 0; prev_rd = -1; steady = 1'b0; fifo_valid = 1'b1;
    @(posedge clk); #1 n_pass = 4'd2; n_rows = 5'd4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t = 0;
    while (reads == 0 && t < 50) begin
      @(negedge clk); #1;
      t++;
    end
    chk("rst_job_read_seen", W'(reads > 0), W'(1));
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); #1;
    chk("abort_busy", W'(busy), '0);
    chk("abort_fifo_rd", W'(fifo_rd), '0);
    chk("abort_done", W'(done), '0);
    stream.delete();
    pend.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("abort_no_rd", W'(fifo_rd), '0);
    end
    run_job(4'd1, 5'd3, 1'b0, 0, 1'b0);
    chk("after_abort_outs", W'(outs_seen), W'(3));

    for (int k = 0; k < 8; k++)
      run_job(4'($urandom_range(0, 4)), 5'($urandom_range(0, 20)), k[0], (k == 2) ? 3 : 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/psum_accum.md
PSUM_ACCUM -- requirements
Module: psum_accum

Interface
REQ-001 The block SHALL have parameter col, default 8, meaning number of array columns (psum lanes per row).
REQ-002 The block SHALL have parameter psum_bw, default 16, meaning width of one signed psum lane.
REQ-003 The block SHALL have parameter acc_depth, default 16, meaning accumulator rows per pass.
REQ-004 The block SHALL have parameter rd_lat, default 2, meaning cycles from fifo_rd assertion to valid fifo_data (range 1..3).
REQ-005 The block SHALL have port clk, input, 1, meaning clock; all logic on rising edge.
REQ-006 The block SHALL have port reset, input, 1, meaning reset, synchronous, active-high.
REQ-007 The block SHALL have port start, input, 1, meaning job start pulse, honoured only in IDLE.
REQ-008 The block SHALL have port n_pass, input, 4, meaning passes to accumulate, sampled at start; 0 treated as 1.
REQ-009 The block SHALL have port n_rows, input, 5, meaning rows per pass, sampled at start; 0 or >acc_depth treated as acc_depth.
REQ-010 The block SHALL have port fifo_valid, input, 1, meaning upstream output FIFO holds at least one full row.
REQ-011 The block SHALL have port fifo_rd, output, 1, meaning one-cycle pop request to upstream FIFO.
REQ-012 The block SHALL have port fifo_data, input, col*psum_bw, meaning popped row, lane i at bits [psum_bw*(i+1)-1 : psum_bw*i].
REQ-013 The block SHALL have port out_valid, output, 1, meaning out_data/out_addr valid this cycle.
REQ-014 The block SHALL have port out_addr, output, 4, meaning row index of out_data.
REQ-015 The block SHALL have port out_data, output, col*psum_bw, meaning ReLU of final accumulated row, same lane packing.
REQ-016 The block SHALL have port busy, output, 1, meaning high in every state except IDLE.
REQ-017 The block SHALL have port done, output, 1, meaning one-cycle pulse at job completion.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT, ACC, DONE.
REQ-019 IDLE->REQ on start; row counter and pass counter cleared to 0; n_pass/n_rows latched.
REQ-020 In REQ, fifo_rd SHALL be asserted for exactly one cycle only when fifo_valid=1, then go to WAIT; else hold REQ with fifo_rd=0.
REQ-021 At most one read SHALL be outstanding; WAIT lasts rd_lat-1 cycles, then ACC, where fifo_data is captured.
REQ-022 In ACC on pass 0, acc[row] SHALL be loaded with fifo_data; on later passes acc[row] += fifo_data per lane, signed, two's-complement wrap to psum_bw.
REQ-023 In ACC on the last pass, out_valid SHALL be asserted that cycle with out_addr=row, out_data lane = max(0, new sum), sign bit set -> 0.
REQ-024 After ACC: row==n_rows-1 wraps row to 0 and increments pass; if that was the last pass go to DONE, else to REQ.
REQ-025 DONE SHALL assert done for one cycle and return to IDLE; start in DONE is ignored.
REQ-026 start while busy SHALL be ignored with no effect on counters.
REQ-027 Throughput SHALL be one row per rd_lat+1 cycles when fifo_valid stays high.
REQ-028 out_valid, fifo_rd, done SHALL be 0 outside the states named above; out_data/out_addr hold last value.

Reset
REQ-029 reset SHALL force IDLE; fifo_rd, out_valid, done, busy = 0; out_addr = 0; out_data = 0; counters = 0.
REQ-030 Accumulator contents need not be cleared; pass 0 overwrites every row used.
REQ-031 reset mid-job SHALL abort immediately with no further fifo_rd; a later start begins a fresh job.

Verification
REQ-032 n_pass=1, n_rows=2, rows {lane0=5, lane1=-3} then {lane0=7} -> out_valid twice, addr 0 lane0=5 lane1=0, addr 1 lane0=7, done one cycle later.
REQ-033 n_pass=3, n_rows=1, lane0 inputs 100,-250,20 -> single out_valid, lane0=0 (sum -130); no out_valid on passes 0,1.
REQ-034 fifo_valid low for 10 cycles in REQ -> fifo_rd stays 0, busy=1, resumes on fifo_valid=1.
REQ-035 n_pass=2, lane0 32767+1 -> wrap to -32768 -> ReLU output 0.
REQ-036 reset asserted in WAIT -> next cycle busy=0, fifo_rd=0; new start with n_pass=1 completes normally.
REQ-037 n_rows=0 -> exactly 16 reads per pass, out_addr 0..15.
